// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatcher slice.
//   car_state_t : 2-bit per-car state as seen on the elevatorStates bus
//   SIM_*       : encodings of the simState control input
//   floor_dist  : absolute distance between two floor indices
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    DOORS = 2'b11
  } car_state_t;

  localparam logic [1:0] SIM_STOP  = 2'b00;
  localparam logic [1:0] SIM_RUN   = 2'b01;
  localparam logic [1:0] SIM_PAUSE = 2'b10;
  localparam logic [1:0] SIM_CLEAR = 2'b11;

  function automatic int floor_dist(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Bus between the people controller and the elevator dispatcher.
//   master : people controller side, drives sim control and call vectors
//   slave  : dispatcher side, returns car states, car floors, pending calls, tick
interface elevator_dispatcher_if #(
  parameter int FLOORS    = 12,
  parameter int ELEVATORS = 4,
  parameter int FLOOR_W   = 4
);

  logic [1:0]                   simState;
  logic [2:0]                   simSpeed;
  logic [FLOORS-1:0]            floorsRequested;
  logic [FLOORS-1:0]            floorDestinations;
  logic [2*ELEVATORS-1:0]       elevatorStates;
  logic [ELEVATORS*FLOOR_W-1:0] carFloors;
  logic [FLOORS-1:0]            pendingFloors;
  logic                         tick;

  modport master (
    output simState, simSpeed, floorsRequested, floorDestinations,
    input  elevatorStates, carFloors, pendingFloors, tick
  );

  modport slave (
    input  simState, simSpeed, floorsRequested, floorDestinations,
    output elevatorStates, carFloors, pendingFloors, tick
  );

endinterface

// File: rtl/elevator_car.sv
// One elevator car: holds its floor, target floor and door counter.
//   clk, rst      : clock and synchronous active-high clear
//   tick          : motion strobe, the car only changes on tick cycles
//   assign_en     : this car is given a new call on this tick
//   assign_floor  : floor of the new call
//   state         : IDLE / UP / DOWN / DOORS
//   floor, target : current floor and floor being travelled to
//   serve         : the car enters DOORS on this tick (its target floor is served)
module elevator_car
  import elevator_pkg::*;
#(
  parameter int FLOOR_W    = 4,
  parameter int DOOR_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               assign_en,
  input  logic [FLOOR_W-1:0] assign_floor,
  output car_state_t         state,
  output logic [FLOOR_W-1:0] floor,
  output logic [FLOOR_W-1:0] target,
  output logic               serve
);

  localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

  logic [DOOR_W-1:0]  door_cnt;
  logic [FLOOR_W-1:0] floor_up;
  logic [FLOOR_W-1:0] floor_dn;

  assign floor_up = floor + FLOOR_W'(1);
  assign floor_dn = floor - FLOOR_W'(1);

  // Serve is raised in the same tick the car arrives, so the top can clear
  // the pending bit on that very edge.
  always_comb begin
    serve = 1'b0;
    if (tick) begin
      case (state)
        IDLE:    serve = assign_en && (assign_floor == floor);
        UP:      serve = (floor_up == target);
        DOWN:    serve = (floor_dn == target);
        default: serve = 1'b0;
      endcase
    end
  end

  // Car FSM. A call at the current floor goes straight to DOORS; arriving
  // at the target also goes straight to DOORS within the same tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor    <= '0;
      target   <= '0;
      door_cnt <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (assign_en) begin
            target <= assign_floor;
            if (assign_floor == floor)
              state <= DOORS;
            else if (assign_floor > floor)
              state <= UP;
            else
              state <= DOWN;
          end
        end
        UP: begin
          floor <= floor_up;
          if (floor_up == target)
            state <= DOORS;
        end
        DOWN: begin
          floor <= floor_dn;
          if (floor_dn == target)
            state <= DOORS;
        end
        DOORS: begin
          if (door_cnt == DOOR_W'(DOOR_TICKS - 1)) begin
            state    <= IDLE;
            door_cnt <= '0;
          end else begin
            door_cnt <= door_cnt + DOOR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Elevator dispatcher: latches hall and car calls, hands pending floors to
// idle cars one per tick, and moves the cars one floor per tick.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of elevator_dispatcher_if
//              in : simState, simSpeed, floorsRequested, floorDestinations
//              out: elevatorStates, carFloors, pendingFloors, tick (all registered)
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int FLOORS     = 12,
  parameter int ELEVATORS  = 4,
  parameter int FLOOR_W    = 4,
  parameter int TICK_BASE  = 16,
  parameter int DOOR_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_dispatcher_if.slave bus
);

  localparam int CNT_W = 16;
  localparam int IDX_W = (ELEVATORS > 1) ? $clog2(ELEVATORS) : 1;

  logic                   clear_all;
  logic                   counting;
  logic [CNT_W-1:0]       period_m1;
  logic [CNT_W-1:0]       tick_cnt;
  logic                   tick_q;
  logic [FLOORS-1:0]      pending;
  logic [FLOORS-1:0]      served;
  logic [FLOORS-1:0]      busy_targets;
  logic [FLOORS-1:0]      candidates;
  logic                   car_found;
  logic [IDX_W-1:0]       car_idx;
  logic [FLOOR_W-1:0]     cur_floor;
  logic                   best_found;
  logic [FLOOR_W-1:0]     best_floor;
  int                     best_dist;
  logic [ELEVATORS-1:0]   assign_vec;

  car_state_t             car_state  [ELEVATORS];
  logic [FLOOR_W-1:0]     car_floor  [ELEVATORS];
  logic [FLOOR_W-1:0]     car_target [ELEVATORS];
  logic                   car_serve  [ELEVATORS];

  logic [2*ELEVATORS-1:0]       states_packed;
  logic [ELEVATORS*FLOOR_W-1:0] floors_packed;

  // Sim-clear behaves exactly like reset for every register in the block.
  assign clear_all = rst || (bus.simState == SIM_CLEAR);
  assign counting  = (bus.simState == SIM_RUN) && (bus.simSpeed != 3'd0);
  assign period_m1 = CNT_W'((8 - int'(bus.simSpeed)) * TICK_BASE - 1);

  // Tick generator. The >= compare lets a speed-up mid-count wrap at once
  // instead of running past the new, shorter period.
  always_ff @(posedge clk) begin
    if (clear_all) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (counting) begin
      if (tick_cnt >= period_m1) begin
        tick_cnt <= '0;
        tick_q   <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
        tick_q   <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // Pending calls accumulate in every sim state; a floor served on the same
  // edge it is requested stays cleared.
  always_ff @(posedge clk) begin
    if (clear_all)
      pending <= '0;
    else
      pending <= (pending | bus.floorsRequested | bus.floorDestinations) & ~served;
  end

  // Assignment scan: lowest-index idle car, nearest pending floor that no
  // busy car is already heading for, ties resolved toward the lower floor.
  always_comb begin
    car_found = 1'b0;
    car_idx   = '0;
    for (int i = ELEVATORS - 1; i >= 0; i--) begin
      if (car_state[i] == IDLE) begin
        car_found = 1'b1;
        car_idx   = IDX_W'(i);
      end
    end

    busy_targets = '0;
    for (int i = 0; i < ELEVATORS; i++) begin
      if (car_state[i] != IDLE) begin
        for (int f = 0; f < FLOORS; f++) begin
          if (car_target[i] == FLOOR_W'(f))
            busy_targets[f] = 1'b1;
        end
      end
    end
    candidates = pending & ~busy_targets;

    cur_floor  = car_floor[car_idx];
    best_found = 1'b0;
    best_floor = '0;
    best_dist  = 0;
    for (int f = 0; f < FLOORS; f++) begin
      if (candidates[f]) begin
        if (!best_found || (floor_dist(f, int'(cur_floor)) < best_dist)) begin
          best_found = 1'b1;
          best_floor = FLOOR_W'(f);
          best_dist  = floor_dist(f, int'(cur_floor));
        end
      end
    end
  end

  // At most one car is handed a call per tick.
  always_comb begin
    assign_vec = '0;
    for (int i = 0; i < ELEVATORS; i++)
      assign_vec[i] = tick_q && car_found && best_found && (car_idx == IDX_W'(i));
  end

  // A car that serves on an assignment tick serves the assigned floor;
  // otherwise it is arriving at its stored target.
  always_comb begin
    served = '0;
    for (int i = 0; i < ELEVATORS; i++) begin
      if (car_serve[i]) begin
        for (int f = 0; f < FLOORS; f++) begin
          if ((assign_vec[i] ? best_floor : car_target[i]) == FLOOR_W'(f))
            served[f] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < ELEVATORS; g++) begin : g_car
    elevator_car #(
      .FLOOR_W    (FLOOR_W),
      .DOOR_TICKS (DOOR_TICKS)
    ) u_car (
      .clk          (clk),
      .rst          (clear_all),
      .tick         (tick_q),
      .assign_en    (assign_vec[g]),
      .assign_floor (best_floor),
      .state        (car_state[g]),
      .floor        (car_floor[g]),
      .target       (car_target[g]),
      .serve        (car_serve[g])
    );
  end

  // Flatten the per-car registers onto the output buses.
  always_comb begin
    states_packed = '0;
    floors_packed = '0;
    for (int i = 0; i < ELEVATORS; i++) begin
      states_packed[2*i +: 2]             = car_state[i];
      floors_packed[FLOOR_W*i +: FLOOR_W] = car_floor[i];
    end
  end

  assign bus.elevatorStates = states_packed;
  assign bus.carFloors      = floors_packed;
  assign bus.pendingFloors  = pending;
  assign bus.tick           = tick_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Self-checking bench for elevator_dispatcher: a table of single-call and
// multi-call scenarios checked through a scoreboard queue, plus hand-written
// sequences for reset, tie-break, freeze, sim-clear and set/clear collision.
module tb_elevator_dispatcher;

  logic clk;
  logic rst;

  elevator_dispatcher_if #(.FLOORS(12), .ELEVATORS(4), .FLOOR_W(4)) bus_if ();

  elevator_dispatcher #(
    .FLOORS     (12),
    .ELEVATORS  (4),
    .FLOOR_W    (4),
    .TICK_BASE  (16),
    .DOOR_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [11:0] req;
    logic [11:0] dest;
    int          ticks;
    logic [7:0]  exp_states;
    logic [15:0] exp_floors;
    logic [11:0] exp_pending;
  } vec_t;

  typedef struct {
    logic [7:0]  states;
    logic [15:0] floors;
    logic [11:0] pending;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];
  int   assertions = 0;
  int   failures   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] req, input logic [11:0] dest);
    bus_if.floorsRequested   = req;
    bus_if.floorDestinations = dest;
    @(negedge clk);
    bus_if.floorsRequested   = '0;
    bus_if.floorDestinations = '0;
  endtask

  task automatic clearSim();
    @(negedge clk);
    bus_if.simState          = 2'b11;
    bus_if.floorsRequested   = '0;
    bus_if.floorDestinations = '0;
    @(negedge clk);
    bus_if.simState = 2'b01;
    bus_if.simSpeed = 3'd7;
  endtask

  // Waits for n tick strobes, then one more cycle so the car update is visible.
  task automatic waitTicks(input int n, input string name);
    int seen;
    int cycles;
    seen   = 0;
    cycles = 0;
    while (seen < n && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (bus_if.tick) seen++;
    end
    if (seen != n)
      checkOutput({name, " tick wait"}, 32'(seen), 32'(n));
    @(negedge clk);
  endtask

  task automatic checkAll(input string name, input logic [7:0] st,
                          input logic [15:0] fl, input logic [11:0] pe);
    checkOutput({name, " states"},  32'(bus_if.elevatorStates), 32'(st));
    checkOutput({name, " floors"},  32'(bus_if.carFloors),      32'(fl));
    checkOutput({name, " pending"}, 32'(bus_if.pendingFloors),  32'(pe));
  endtask

  initial begin
    exp_t exp;
    int   ticks_seen;
    logic found;

    vecs[0] = '{12'h020, 12'h000, 1,  8'h01, 16'h0000, 12'h020};
    vecs[1] = '{12'h020, 12'h000, 6,  8'h03, 16'h0005, 12'h000};
    vecs[2] = '{12'h020, 12'h000, 8,  8'h00, 16'h0005, 12'h000};
    vecs[3] = '{12'h000, 12'h001, 1,  8'h03, 16'h0000, 12'h000};
    vecs[4] = '{12'h208, 12'h000, 1,  8'h01, 16'h0000, 12'h208};
    vecs[5] = '{12'h208, 12'h000, 2,  8'h05, 16'h0001, 12'h208};
    vecs[6] = '{12'h208, 12'h000, 4,  8'h07, 16'h0023, 12'h200};
    vecs[7] = '{12'h208, 12'h000, 11, 8'h0C, 16'h0093, 12'h000};
    vecs[8] = '{12'h002, 12'h800, 2,  8'h07, 16'h0001, 12'h800};
    vecs[9] = '{12'h800, 12'h000, 3,  8'h01, 16'h0002, 12'h800};

    rst                      = 1'b1;
    bus_if.simState          = 2'b00;
    bus_if.simSpeed          = 3'd0;
    bus_if.floorsRequested   = '0;
    bus_if.floorDestinations = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAll("reset", 8'h00, 16'h0000, 12'h000);
    checkOutput("reset tick", 32'(bus_if.tick), 32'd0);

    // Call is latched into pending on the very next edge
    clearSim();
    applyStimulus(12'h020, 12'h000);
    checkOutput("latch pending", 32'(bus_if.pendingFloors), 32'h020);

    // Table-driven scenarios, each from a sim-clear
    foreach (vecs[k]) begin
      clearSim();
      applyStimulus(vecs[k].req, vecs[k].dest);
      sb_q.push_back('{vecs[k].exp_states, vecs[k].exp_floors, vecs[k].exp_pending});
      waitTicks(vecs[k].ticks, $sformatf("vec%0d", k));
      exp = sb_q.pop_front();
      checkAll($sformatf("vec%0d", k), exp.states, exp.floors, exp.pending);
    end

    // Tie-break: car idle at floor 4, calls at 2 and 6 -> goes DOWN to 2
    clearSim();
    applyStimulus(12'h010, 12'h000);
    waitTicks(7, "tie setup");
    checkAll("tie setup", 8'h00, 16'h0004, 12'h000);
    applyStimulus(12'h044, 12'h000);
    waitTicks(1, "tie");
    checkAll("tie", 8'h02, 16'h0004, 12'h044);

    // Freeze by pause with a car moving UP at floor 2
    clearSim();
    applyStimulus(12'h200, 12'h000);
    waitTicks(3, "freeze setup");
    checkAll("freeze setup", 8'h01, 16'h0002, 12'h200);
    bus_if.simState = 2'b10;
    ticks_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.tick) ticks_seen++;
      if (i == 50) bus_if.floorsRequested = 12'h080;
      if (i == 51) bus_if.floorsRequested = 12'h000;
    end
    checkOutput("pause ticks", 32'(ticks_seen), 32'd0);
    checkAll("pause", 8'h01, 16'h0002, 12'h280);

    // Freeze by zero speed while running
    bus_if.simState = 2'b01;
    bus_if.simSpeed = 3'd0;
    ticks_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.tick) ticks_seen++;
    end
    checkOutput("speed0 ticks", 32'(ticks_seen), 32'd0);
    checkAll("speed0", 8'h01, 16'h0002, 12'h280);

    // Sim-clear empties everything on the next edge
    bus_if.simState = 2'b11;
    @(negedge clk);
    checkAll("simclear", 8'h00, 16'h0000, 12'h000);
    checkOutput("simclear tick", 32'(bus_if.tick), 32'd0);

    // Set/clear collision: request floor 4 again on the arrival tick
    clearSim();
    applyStimulus(12'h010, 12'h000);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus_if.tick && bus_if.carFloors[3:0] == 4'd3 && bus_if.elevatorStates[1:0] == 2'b01) begin
        found = 1'b1;
        bus_if.floorsRequested = 12'h010;
      end
    end
    checkOutput("collision reached", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    bus_if.floorsRequested = 12'h000;
    @(negedge clk);
    checkAll("collision", 8'h03, 16'h0004, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
- Consumes the people controller's per-floor call vectors `floorsRequested` and `floorDestinations`.
- Latches them into a pending-call register and assigns pending floors to idle cars.
- Moves each car one floor per simulation tick and opens its doors on arrival.
- Produces the 2-bit-per-car `elevatorStates` bus that the people controller consumes, plus car positions for the display path.

Parameters:
- FLOORS, 12, number of floors; one bit per floor in the call vectors.
- ELEVATORS, 4, number of cars.
- FLOOR_W, 4, width of one car floor index.
- TICK_BASE, 16, clock cycles per speed unit.
- DOOR_TICKS, 2, ticks a car stays in DOORS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- simState  in  2  00 stop, 01 run, 10 pause, 11 sim-clear
- simSpeed  in  3  0 = no motion; else tick period = (8-simSpeed)*TICK_BASE cycles
- floorsRequested  in  FLOORS  hall-call pulses/levels, bit f = floor f
- floorDestinations  in  FLOORS  car-call pulses/levels, bit f = floor f
- elevatorStates  out  2*ELEVATORS  car i at [2i+1:2i]: 00 IDLE, 01 UP, 10 DOWN, 11 DOORS
- carFloors  out  ELEVATORS*FLOOR_W  car i floor at [FLOOR_W*i +: FLOOR_W]
- pendingFloors  out  FLOORS  outstanding unserved calls
- tick  out  1  one-cycle motion strobe

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset: all outputs 0; all cars IDLE at floor 0; targets, door counters and tick counter 0.
- simState=11 has the same effect as rst.
- Tick counter:
  - Counts only when simState=01 and simSpeed≠0; otherwise it holds and tick=0.
  - When count ≥ period-1: tick=1 for that cycle and the counter wraps to 0.
  - The ≥ compare covers a simSpeed increase mid-count.
- Pending register, updated every cycle regardless of simState:
  - pending ← (pending | floorsRequested | floorDestinations) & ~served.
  - served = floors at which a car enters DOORS this cycle.
  - When set and clear hit the same bit in the same cycle, clear wins.
- Registered outputs: pendingFloors = pending register; elevatorStates and carFloors are car registers. No combinational input-to-output paths.
- All car updates occur only in tick cycles.
- Assignment (at most one per tick):
  - Candidate car: lowest-index IDLE car.
  - Candidate floors: pending bits not equal to any other non-IDLE car's target.
  - Choose the floor nearest to the car's current floor; a distance tie goes to the lower floor.
  - If the chosen floor equals the current floor: car → DOORS, floor served.
  - If above: target ← floor, car → UP. If below: target ← floor, car → DOWN.
  - No eligible floor: car stays IDLE.
- UP/DOWN: floor ± 1 per tick. When the new floor equals target: car → DOORS in the same tick and the floor is served.
- DOORS: door counter increments per tick; when it reaches DOOR_TICKS the car → IDLE and the counter clears.
- Floor arithmetic is unsigned FLOOR_W. UP never exceeds FLOORS-1 and DOWN never goes below 0, because targets are always valid floors.
- Pause (10) or stop (00): no ticks, so car state freezes; pending still accumulates.
- rst mid-motion: all cars return to floor 0 IDLE on the next edge; in-flight targets are lost.

Decomposition:
- Package `elevator_pkg`:
  - enum car_state_t {IDLE=2'b00, UP=2'b01, DOWN=2'b10, DOORS=2'b11}
  - sim-state constants SIM_STOP, SIM_RUN, SIM_PAUSE, SIM_CLEAR
- Sub-module `elevator_car`: per-car FSM holding floor, target and door counter. Inputs: tick, assign strobe, assign floor. Outputs: state, floor, serve strobe.
- Top level owns the tick generator, pending register and assignment scan, and instantiates ELEVATORS cars via generate.

Test Plan:
- Reset: assert rst 2 cycles → elevatorStates=8'h00, carFloors=16'h0000, pendingFloors=12'h000, tick=0.
- Single call:
  - simState=01, simSpeed=7 (tick every 16 cycles), floorsRequested=12'h020 for one cycle → pendingFloors=12'h020 next cycle.
  - Tick 1: car0 state 01.
  - Tick 6: carFloors[3:0]=5, state 11, pending 12'h000.
  - Tick 8: state 00.
- Local call: car0 idle at 0, floorDestinations=12'h001 → tick 1: elevatorStates[1:0]=11, pendingFloors=0, other cars 00.
- Two calls: floorsRequested=12'h208 (floors 3, 9) in one cycle → tick 1: car0 UP to target 3; tick 2: car1 UP to target 9; car0 reaches floor 3 DOORS at tick 4, car1 reaches floor 9 at tick 11.
- Freeze:
  - Car moving UP at floor 2, simState←10 for 100 cycles → tick=0 and carFloors/elevatorStates unchanged; requests arriving meanwhile appear in pendingFloors.
  - simSpeed=0 gives the same freeze.
  - simState=11 → all outputs 0 next cycle.
- Set/clear collision: car arriving at floor 4 on a tick while floorsRequested[4]=1 that same cycle → pendingFloors[4]=0 after the edge.
